// File: rtl/umi_endpoint_pipe_pkg.sv
// rtl/umi_endpoint_pipe_pkg.sv - UMI opcodes, command field layout and request decode helper
package umi_endpoint_pipe_pkg;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 8;
  localparam int SIZE_LSB   = 8;
  localparam int SIZE_W     = 4;
  localparam int USER_LSB   = 12;
  localparam int USER_W     = 20;

  localparam logic [7:0] UMI_OP_INVALID    = 8'h00;
  localparam logic [7:0] UMI_OP_REQ_READ   = 8'h01;
  localparam logic [7:0] UMI_OP_RESP_READ  = 8'h02;
  localparam logic [7:0] UMI_OP_REQ_WRITE  = 8'h03;
  localparam logic [7:0] UMI_OP_RESP_WRITE = 8'h04;
  localparam logic [7:0] UMI_OP_REQ_POSTED = 8'h05;
  localparam logic [7:0] UMI_OP_REQ_ATOMIC = 8'h09;

  typedef struct packed {
    logic [USER_W-1:0]   user;
    logic [SIZE_W-1:0]   size;
    logic [OPCODE_W-1:0] opcode;
  } umi_cmd_t;

  localparam int HDR_W = $bits(umi_cmd_t);

  typedef enum logic [1:0] {
    REQ_INVALID,
    REQ_READ,
    REQ_WRITE,
    REQ_WRITE_ACK
  } req_kind_e;

  // Atomics and any response opcode arriving on the request side are invalid here.
  function automatic req_kind_e decode_opcode(input logic [OPCODE_W-1:0] op);
    case (op)
      UMI_OP_REQ_READ:   return REQ_READ;
      UMI_OP_REQ_WRITE:  return REQ_WRITE_ACK;
      UMI_OP_REQ_POSTED: return REQ_WRITE;
      default:           return REQ_INVALID;
    endcase
  endfunction

endpackage

// File: rtl/umi_endpoint_pipe_fifo.sv
// rtl/umi_endpoint_pipe_fifo.sv - synchronous response FIFO with occupancy count
module umi_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTRW = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/umi_endpoint_pipe.sv
// rtl/umi_endpoint_pipe.sv - UMI endpoint with fixed-latency read pipe and credit-guarded response FIFO (option: UMI_ENDPOINT_WRACK_EN)
module umi_endpoint_pipe
  import umi_endpoint_pipe_pkg::*;
#(
  parameter int AW    = 64,
  parameter int DW    = 64,
  parameter int UW    = 256,
  parameter int RLAT  = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  input  logic [UW-1:0] umi_in_packet,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [UW-1:0] umi_out_packet,
  input  logic          umi_out_ready,
  output logic [AW-1:0] addr,
  output logic          write,
  output logic          read,
  output logic [31:0]   cmd,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          err_invalid
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int DOFF = HDR_W + 2*AW;
  localparam int PW   = HDR_W + AW;
  localparam int FW   = PW + DW;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  umi_cmd_t        req_cmd;
  logic [AW-1:0]   req_src;
  req_kind_e       kind;
  logic            rst_done;
  logic            accept;
  logic            acc_v;
  logic [7:0]      resp_op;
  logic [PW-1:0]   acc_e;
  logic            push_v;
  logic [PW-1:0]   push_e;
  logic [DW-1:0]   resp_data;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            empty;
  logic            pop;
  logic [FW-1:0]   pop_data;
  logic            unused_pkt;

  assign req_cmd    = umi_in_packet[HDR_W-1:0];
  assign addr       = umi_in_packet[HDR_W +: AW];
  assign req_src    = umi_in_packet[HDR_W+AW +: AW];
  assign write_data = umi_in_packet[DOFF +: DW];
  assign cmd        = req_cmd;
  assign kind       = decode_opcode(req_cmd.opcode);
  assign unused_pkt = ^umi_in_packet;

  // Holds ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) rst_done <= 1'b0;
    else         rst_done <= 1'b1;
  end

  assign used         = {1'b0, count} + {1'b0, inflight};
  assign umi_in_ready = rst_done && (used < DEPTH_V);
  assign accept       = umi_in_valid && umi_in_ready;
  assign read         = accept && (kind == REQ_READ);
  assign write        = accept && ((kind == REQ_WRITE) || (kind == REQ_WRITE_ACK));
  assign err_invalid  = accept && (kind == REQ_INVALID);

`ifdef UMI_ENDPOINT_WRACK_EN
  assign acc_v   = accept && ((kind == REQ_READ) || (kind == REQ_WRITE_ACK));
  assign resp_op = (kind == REQ_WRITE_ACK) ? UMI_OP_RESP_WRITE : UMI_OP_RESP_READ;
`else
  assign acc_v   = read;
  assign resp_op = UMI_OP_RESP_READ;
`endif

  // Pipe entry is the future response header: {user, size, opcode, dstaddr<=srcaddr}.
  assign acc_e = {req_cmd.user, req_cmd.size, resp_op, req_src};

  generate
    if (RLAT == 0) begin : g_nopipe
      assign push_v   = acc_v;
      assign push_e   = acc_e;
      assign inflight = '0;
    end else begin : g_pipe
      logic [RLAT-1:0] pipe_v;
      logic [PW-1:0]   pipe_e [RLAT];

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          pipe_v <= '0;
        end else begin
          pipe_v[0] <= acc_v;
          for (int k = 1; k < RLAT; k++) pipe_v[k] <= pipe_v[k-1];
        end
      end

      always_ff @(posedge clk) begin
        pipe_e[0] <= acc_e;
        for (int k = 1; k < RLAT; k++) pipe_e[k] <= pipe_e[k-1];
      end

      always_comb begin
        inflight = '0;
        for (int k = 0; k < RLAT; k++) inflight = inflight + CW'(pipe_v[k]);
      end

      assign push_v = pipe_v[RLAT-1];
      assign push_e = pipe_e[RLAT-1];
    end
  endgenerate

  // read_data lines up with the last pipe stage; write acks carry no data.
  assign resp_data = (push_e[AW +: OPCODE_W] == UMI_OP_RESP_WRITE) ? '0 : read_data;

  umi_resp_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .push      (push_v),
    .push_data ({resp_data, push_e}),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (empty),
    .count     (count)
  );

  assign umi_out_valid = !empty;
  assign pop           = umi_out_valid && umi_out_ready;

  // Response srcaddr stays zero.
  always_comb begin
    umi_out_packet                 = '0;
    umi_out_packet[HDR_W-1:0]      = pop_data[AW +: HDR_W];
    umi_out_packet[HDR_W +: AW]    = pop_data[AW-1:0];
    umi_out_packet[DOFF +: DW]     = pop_data[PW +: DW];
  end

endmodule

// File: tb/tb_umi_endpoint_pipe.sv
// tb/tb_umi_endpoint_pipe.sv - self-checking bench for umi_endpoint_pipe against a transaction-level model
module tb_umi_endpoint_pipe;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int UW    = 256;
  localparam int RLAT  = 2;
  localparam int DEPTH = 4;
`ifdef UMI_ENDPOINT_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          in_valid = 1'b0;
  logic [UW-1:0] in_pkt = '0;
  logic          in_ready;
  logic          out_valid;
  logic [UW-1:0] out_pkt;
  logic          out_ready = 1'b0;
  logic [AW-1:0] addr;
  logic          write;
  logic          read;
  logic [31:0]   cmd;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          err;

  umi_endpoint_pipe #(.AW(AW), .DW(DW), .UW(UW), .RLAT(RLAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .umi_in_valid(in_valid), .umi_in_packet(in_pkt), .umi_in_ready(in_ready),
    .umi_out_valid(out_valid), .umi_out_packet(out_pkt), .umi_out_ready(out_ready),
    .addr(addr), .write(write), .read(read), .cmd(cmd), .write_data(write_data),
    .read_data(read_data), .err_invalid(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd_fn(input logic [63:0] a);
    if (a == 64'h1000) return 64'hDEAD;
    return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Memory target: data for an address appears RLAT cycles after it was presented.
  logic [63:0] hist [RLAT];
  always @(posedge clk) begin
    hist[0] <= addr;
    for (int k = 1; k < RLAT; k++) hist[k] <= hist[k-1];
  end
  assign read_data = rd_fn(hist[RLAT-1]);

  function automatic logic [UW-1:0] mkpkt(input logic [7:0] op, input logic [3:0] size,
                                          input logic [19:0] user, input logic [63:0] dst,
                                          input logic [63:0] src, input logic [63:0] data);
    return {32'h0, data, src, dst, user, size, op};
  endfunction

  typedef struct {
    logic [UW-1:0] pkt;
    int            due;
  } rsp_t;

  rsp_t exp_q[$];
  int   cyc = 0;
  int   outstanding = 0;
  bit   rdy_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   last_rd, last_wr, last_err, last_rdy, last_ov, last_pop;
  logic [UW-1:0] last_pkt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic reset_model();
    exp_q.delete();
    outstanding = 0;
    rdy_en = 1'b0;
  endtask

  // One clock: check DUT against the model, then advance the model across the edge.
  task automatic tick();
    logic [7:0] op;
    bit is_rd, is_wr, is_ack, rsp, e_rdy, acc, e_ov;
    rsp_t r;
    op     = in_pkt[7:0];
    is_rd  = (op == 8'h01);
    is_wr  = (op == 8'h03) || (op == 8'h05);
    is_ack = (op == 8'h03);
    rsp    = is_rd || (WRACK && is_ack);
    e_rdy  = rdy_en && (outstanding < DEPTH);
    acc    = in_valid && e_rdy;
    e_ov   = (exp_q.size() != 0) && (exp_q[0].due <= cyc);
    @(negedge clk);
    chk("in_ready", in_ready, e_rdy);
    chk("read", read, acc && is_rd);
    chk("write", write, acc && is_wr);
    chk("err_invalid", err, acc && !is_rd && !is_wr);
    chk("addr", addr, in_pkt[95:32]);
    chk("cmd", cmd, in_pkt[31:0]);
    chk("write_data", write_data, in_pkt[223:160]);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) chk("out_packet", out_pkt, exp_q[0].pkt);
    chk("fifo_no_overflow", dut.u_fifo.push && (dut.u_fifo.count == 3'(DEPTH)), 1'b0);
    last_rd = read; last_wr = write; last_err = err; last_rdy = in_ready;
    last_ov = out_valid; last_pkt = out_pkt; last_pop = out_valid && out_ready;
    if (e_ov && out_ready) begin
      void'(exp_q.pop_front());
      outstanding--;
    end
    if (acc && rsp) begin
      r.pkt = mkpkt(is_rd ? 8'h02 : 8'h04, in_pkt[11:8], in_pkt[31:12], in_pkt[159:96],
                    64'h0, is_rd ? rd_fn(in_pkt[95:32]) : 64'h0);
      r.due = cyc + RLAT + 1;
      exp_q.push_back(r);
      outstanding++;
    end
    if (nreset) rdy_en = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [63:0] dst;
    logic [63:0] data;
    bit          e_rd, e_wr, e_err;
    int          e_rsp;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int lat, nacc, npop, nbusy, n;
    tbl[0] = '{8'h01, 64'h40, 64'h0,  1'b1, 1'b0, 1'b0, 1};
    tbl[1] = '{8'h03, 64'h20, 64'h55, 1'b0, 1'b1, 1'b0, WRACK ? 1 : 0};
    tbl[2] = '{8'h05, 64'h20, 64'h55, 1'b0, 1'b1, 1'b0, 0};
    tbl[3] = '{8'h09, 64'h80, 64'h7,  1'b0, 1'b0, 1'b1, 0};
    tbl[4] = '{8'h00, 64'h90, 64'h0,  1'b0, 1'b0, 1'b1, 0};
    tbl[5] = '{8'h02, 64'hA0, 64'h0,  1'b0, 1'b0, 1'b1, 0};

    // Reset: a pending read must not strobe or be accepted.
    reset_model();
    in_valid = 1'b1;
    in_pkt = mkpkt(8'h01, 4'h3, 20'h1, 64'h1000, 64'hA0, 64'h0);
    tick();
    tick();
    chk("reset_fifo_count", dut.u_fifo.count, 0);
    in_valid = 1'b0;
    nreset = 1'b1;
    tick();
    tick();

    // Read latency RLAT+1 with a known memory word.
    out_ready = 1'b0;
    in_pkt = mkpkt(8'h01, 4'h3, 20'hABCDE, 64'h1000, 64'hA0, 64'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      lat++;
      tick();
      if (last_ov) break;
    end
    chk("t1_latency", lat, RLAT + 1);
    chk("t1_dst", last_pkt[95:32], 64'hA0);
    chk("t1_data", last_pkt[223:160], 64'hDEAD);
    chk("t1_opcode", last_pkt[7:0], 8'h02);
    out_ready = 1'b1;
    repeat (2) tick();

    // Decode table: one request at a time, then drain.
    foreach (tbl[i]) begin
      in_pkt = mkpkt(tbl[i].op, 4'h2, 20'h00100 + i, tbl[i].dst, 64'h300 + i, tbl[i].data);
      in_valid = 1'b1;
      tick();
      chk("tbl_read", last_rd, tbl[i].e_rd);
      chk("tbl_write", last_wr, tbl[i].e_wr);
      chk("tbl_err", last_err, tbl[i].e_err);
      in_valid = 1'b0;
      npop = 0;
      repeat (RLAT + 3) begin
        tick();
        npop += int'(last_pop);
      end
      chk("tbl_responses", npop, tbl[i].e_rsp);
    end

    // Backpressure: only DEPTH reads get in, then they drain in order.
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      in_pkt = mkpkt(8'h01, 4'h1, 20'h200 + i, 64'h500 + 64'(i * 8), 64'h10 * i, 64'h0);
      in_valid = 1'b1;
      tick();
      nacc += int'(last_rd);
    end
    in_valid = 1'b0;
    tick();
    chk("t2_accepted", nacc, DEPTH);
    chk("t2_ready_low", last_rdy, 1'b0);
    out_ready = 1'b1;
    npop = 0;
    repeat (10) begin
      tick();
      npop += int'(last_pop);
    end
    chk("t2_drained", npop, DEPTH);

    // Back-to-back reads with a free-flowing output keep ready high.
    out_ready = 1'b1;
    nbusy = 0;
    npop = 0;
    for (int i = 0; i < 12; i++) begin
      in_pkt = mkpkt(8'h01, 4'h0, 20'h300 + i, 64'h700 + 64'(i), 64'h20 + 64'(i), 64'h0);
      in_valid = 1'b1;
      tick();
      nbusy += int'(!last_rdy);
      npop += int'(last_pop);
    end
    in_valid = 1'b0;
    repeat (RLAT + 3) begin
      tick();
      npop += int'(last_pop);
    end
    chk("t3_never_busy", nbusy, 0);
    chk("t3_responses", npop, 12);

`ifdef UMI_ENDPOINT_WRACK_EN
    // Acked write followed by a read: responses stay in request order.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pkt = mkpkt(8'h03, 4'h2, 20'h44, 64'h60, 64'hB0, 64'h99);
    tick();
    chk("t5_write_strobe", last_wr, 1'b1);
    in_pkt = mkpkt(8'h01, 4'h2, 20'h45, 64'h68, 64'hB8, 64'h0);
    tick();
    in_valid = 1'b0;
    repeat (RLAT + 1) tick();
    out_ready = 1'b1;
    tick();
    chk("t5_first_op", last_pkt[7:0], 8'h04);
    tick();
    chk("t5_second_op", last_pkt[7:0], 8'h02);
    repeat (2) tick();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 5))
        0, 1, 2: op = 8'h01;
        3:       op = 8'h03;
        4:       op = 8'h05;
        default: op = 8'($urandom_range(0, 255));
      endcase
      in_pkt = mkpkt(op, 4'($urandom), 20'($urandom), {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom});
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("rand_drain_bound", n < 40, 1'b1);

    // Reset with responses queued discards them.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_pkt = mkpkt(8'h01, 4'h1, 20'h600 + i, 64'h900 + 64'(i), 64'h40 + 64'(i), 64'h0);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (RLAT + 1) tick();
    chk("t6_queued", dut.u_fifo.count, 3);
    nreset = 1'b0;
    reset_model();
    tick();
    chk("t6_valid_low", last_ov, 1'b0);
    tick();
    nreset = 1'b1;
    tick();
    tick();
    chk("t6_ready_back", last_rdy, 1'b1);
    chk("t6_fifo_empty", dut.u_fifo.count, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
